// File: rtl/data_ram_ctrl_pkg.sv
// Shared definitions for the data-RAM responder: word/address widths,
// default geometry and latencies, controller state type and a range helper.
package data_ram_ctrl_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int BUS_WIDTH      = 8;
    localparam int RAM_DEPTH_DEF  = 256;
    localparam int RD_LATENCY_DEF = 1;
    localparam int WR_LATENCY_DEF = 1;

    typedef enum logic {RIDLE, RACTIVE} RamState;

    // True when a full-width address falls inside a storage array of 'depth' words.
    function automatic logic addr_in_range(input logic [BUS_WIDTH-1:0] addr, input int depth);
        return ({{(32-BUS_WIDTH){1'b0}}, addr} < depth[31:0]);
    endfunction

endpackage

// File: rtl/data_ram_ctrl_if.sv
// Core <-> data-RAM request/response bundle. The core side is the master,
// the RAM controller is the slave.
interface data_ram_ctrl_if;
    import data_ram_ctrl_pkg::*;

    logic                  ram_rd_en;
    logic                  ram_wr_en;
    logic [BUS_WIDTH-1:0]  addr_rd;
    logic [BUS_WIDTH-1:0]  addr_wr;
    logic [DATA_WIDTH-1:0] data_wr;
    logic [DATA_WIDTH-1:0] data_rd;
    logic                  rd_valid;
    logic                  ram_busy;
    logic                  err;

    modport master (
        output ram_rd_en, ram_wr_en, addr_rd, addr_wr, data_wr,
        input  data_rd, rd_valid, ram_busy, err
    );

    modport slave (
        input  ram_rd_en, ram_wr_en, addr_rd, addr_wr, data_wr,
        output data_rd, rd_valid, ram_busy, err
    );

endinterface

// File: rtl/data_ram_ctrl_ram_array.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one combinational
// read port. Out-of-range reads return zero and out-of-range writes are ignored,
// so a short array never aliases onto its low addresses. Contents are not reset.
module ram_array
    import data_ram_ctrl_pkg::*;
#(
    parameter int DEPTH = RAM_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [BUS_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BUS_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0]      widx;
    logic [IDX_W-1:0]      ridx;

    assign widx = waddr[IDX_W-1:0];
    assign ridx = raddr[IDX_W-1:0];

    // Asynchronous read, guarded against addresses beyond the array.
    always_comb begin
        rdata = '0;
        if (addr_in_range(raddr, DEPTH)) rdata = mem[ridx];
    end

    // Synchronous write of in-range addresses only.
    always_ff @(posedge clk) begin
        if (we && addr_in_range(waddr, DEPTH)) mem[widx] <= wdata;
    end

endmodule

// File: rtl/data_ram_ctrl.sv
// Responder end of the core's data-RAM interface. Accepts one read and/or write
// request while idle, snapshots the read word at the accept edge (so a same-address
// write never leaks into the read), then counts down the longer of the active
// latencies, delivering the read and committing the write each at its own latency.
module data_ram_ctrl
    import data_ram_ctrl_pkg::*;
#(
    parameter int RAM_DEPTH  = RAM_DEPTH_DEF,
    parameter int RD_LATENCY = RD_LATENCY_DEF,
    parameter int WR_LATENCY = WR_LATENCY_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    data_ram_ctrl_if.slave  bus
);

    localparam logic [3:0] RD_LAT = 4'(RD_LATENCY);
    localparam logic [3:0] WR_LAT = 4'(WR_LATENCY);

    RamState               state;
    logic [3:0]            cnt;
    logic [3:0]            rd_fire;
    logic [3:0]            wr_fire;
    logic                  rd_pend;
    logic                  wr_pend;
    logic                  busy;
    logic                  rd_valid;
    logic                  err;
    logic [DATA_WIDTH-1:0] data_rd;

    logic [BUS_WIDTH-1:0]  waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  wr_ok;

    logic                  accept;
    logic                  rd_in;
    logic                  wr_in;
    logic [3:0]            lat;
    logic                  rd_done;
    logic                  wr_commit;
    logic [DATA_WIDTH-1:0] arr_rdata;

    assign accept = !busy && (bus.ram_rd_en || bus.ram_wr_en);
    assign rd_in  = addr_in_range(bus.addr_rd, RAM_DEPTH);
    assign wr_in  = addr_in_range(bus.addr_wr, RAM_DEPTH);

    // Request latency is the longer of the latencies of the operations present.
    always_comb begin
        lat = 4'd0;
        if (bus.ram_rd_en) lat = RD_LAT;
        if (bus.ram_wr_en && (WR_LAT > lat)) lat = WR_LAT;
    end

    // cnt runs lat..1; an operation of latency X fires when cnt == lat - X + 1.
    assign rd_done   = (state == RACTIVE) && rd_pend && (cnt == rd_fire);
    assign wr_commit = (state == RACTIVE) && wr_pend && wr_ok && (cnt == wr_fire);

    // Control FSM: accept, countdown, completion and output pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= RIDLE;
            cnt      <= 4'd0;
            rd_fire  <= 4'd0;
            wr_fire  <= 4'd0;
            rd_pend  <= 1'b0;
            wr_pend  <= 1'b0;
            busy     <= 1'b0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
            data_rd  <= '0;
        end else begin
            rd_valid <= 1'b0;
            err      <= 1'b0;
            case (state)
                RIDLE: begin
                    if (accept) begin
                        state   <= RACTIVE;
                        busy    <= 1'b1;
                        cnt     <= lat;
                        rd_fire <= lat - RD_LAT + 4'd1;
                        wr_fire <= lat - WR_LAT + 4'd1;
                        rd_pend <= bus.ram_rd_en;
                        wr_pend <= bus.ram_wr_en;
                        err     <= (bus.ram_rd_en && !rd_in) || (bus.ram_wr_en && !wr_in);
                    end
                end
                RACTIVE: begin
                    cnt <= cnt - 4'd1;
                    if (rd_done) begin
                        data_rd  <= rd_word;
                        rd_valid <= 1'b1;
                    end
                    if (cnt == 4'd1) begin
                        state   <= RIDLE;
                        busy    <= 1'b0;
                        rd_pend <= 1'b0;
                        wr_pend <= 1'b0;
                    end
                end
                default: state <= RIDLE;
            endcase
        end
    end

    // Request data latches: write target/data and the read snapshot, taken on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            waddr_q <= bus.addr_wr;
            wdata_q <= bus.data_wr;
            wr_ok   <= wr_in;
            rd_word <= rd_in ? arr_rdata : '0;
        end
    end

    ram_array #(
        .DEPTH (RAM_DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (wr_commit),
        .waddr (waddr_q),
        .wdata (wdata_q),
        .raddr (bus.addr_rd),
        .rdata (arr_rdata)
    );

    assign bus.data_rd  = data_rd;
    assign bus.rd_valid = rd_valid;
    assign bus.ram_busy = busy;
    assign bus.err      = err;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Bench for data_ram_ctrl: two instances (default geometry, and a 128-word array
// with read latency 3 / write latency 4), a per-instance memory image as the
// reference, directed scenarios and randomized request streams.
module tb_data_ram_ctrl;

    localparam int A_DEPTH = 256;
    localparam int A_RD    = 1;
    localparam int A_WR    = 1;
    localparam int B_DEPTH = 128;
    localparam int B_RD    = 3;
    localparam int B_WR    = 4;

    logic clk = 1'b0;
    logic rstn_a;
    logic rstn_b;

    data_ram_ctrl_if ifa ();
    data_ram_ctrl_if ifb ();

    data_ram_ctrl #(.RAM_DEPTH(A_DEPTH), .RD_LATENCY(A_RD), .WR_LATENCY(A_WR)) dut_a (
        .clk  (clk),
        .rstn (rstn_a),
        .bus  (ifa)
    );

    data_ram_ctrl #(.RAM_DEPTH(B_DEPTH), .RD_LATENCY(B_RD), .WR_LATENCY(B_WR)) dut_b (
        .clk  (clk),
        .rstn (rstn_b),
        .bus  (ifb)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] model   [2][256];
    logic [7:0] last_rd [2];

    function automatic int depth_of(input int inst);
        return (inst == 0) ? A_DEPTH : B_DEPTH;
    endfunction

    function automatic int rd_lat_of(input int inst);
        return (inst == 0) ? A_RD : B_RD;
    endfunction

    function automatic int wr_lat_of(input int inst);
        return (inst == 0) ? A_WR : B_WR;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int inst, input bit rd, input bit wr,
                         input int ar, input int aw, input int dw);
        if (inst == 0) begin
            ifa.ram_rd_en = rd;
            ifa.ram_wr_en = wr;
            ifa.addr_rd   = 8'(ar);
            ifa.addr_wr   = 8'(aw);
            ifa.data_wr   = 8'(dw);
        end else begin
            ifb.ram_rd_en = rd;
            ifb.ram_wr_en = wr;
            ifb.addr_rd   = 8'(ar);
            ifb.addr_wr   = 8'(aw);
            ifb.data_wr   = 8'(dw);
        end
    endtask

    task automatic expect_outputs(input int inst, input string tag, input bit eb,
                                  input bit ev, input bit ee, input logic [7:0] ed);
        logic       b, v, e;
        logic [7:0] d;
        if (inst == 0) begin
            b = ifa.ram_busy; v = ifa.rd_valid; e = ifa.err; d = ifa.data_rd;
        end else begin
            b = ifb.ram_busy; v = ifb.rd_valid; e = ifb.err; d = ifb.data_rd;
        end
        chk({tag, ".busy"},     32'(b), 32'(eb));
        chk({tag, ".rd_valid"}, 32'(v), 32'(ev));
        chk({tag, ".err"},      32'(e), 32'(ee));
        chk({tag, ".data_rd"},  32'(d), 32'(ed));
    endtask

    // Issue one request from an idle negedge and follow it to completion.
    // Returns at the negedge after the last busy cycle (controller idle again).
    task automatic run_req(input int inst, input string tag, input bit rd, input bit wr,
                           input int ar, input int aw, input int dw, input bit poke);
        int         dep, rdl, wrl, lat;
        bit         oor;
        logic [7:0] exp_rd, old_rd;
        dep = depth_of(inst);
        rdl = rd_lat_of(inst);
        wrl = wr_lat_of(inst);
        lat = 0;
        if (rd) lat = rdl;
        if (wr && wrl > lat) lat = wrl;
        old_rd = last_rd[inst];
        exp_rd = (ar < dep) ? model[inst][ar] : 8'h00;
        oor    = (rd && ar >= dep) || (wr && aw >= dep);
        drive(inst, rd, wr, ar, aw, dw);
        @(negedge clk);
        expect_outputs(inst, {tag, "@acc"}, 1'b1, 1'b0, oor, old_rd);
        if (poke) drive(inst, 1'b0, 1'b1, 0, ar, 255 - int'(exp_rd));
        else      drive(inst, 1'b0, 1'b0, 0, 0, 0);
        for (int j = 1; j <= lat; j++) begin
            @(negedge clk);
            expect_outputs(inst, $sformatf("%s@%0d", tag, j), (j < lat), rd && (j == rdl),
                           1'b0, (rd && j >= rdl) ? exp_rd : old_rd);
            if (j == 1) drive(inst, 1'b0, 1'b0, 0, 0, 0);
        end
        if (wr && aw < dep) model[inst][aw] = 8'(dw);
        if (rd) last_rd[inst] = exp_rd;
    endtask

    // Directed scenarios followed by randomized request streams.
    initial begin
        int ar, aw, dw;
        bit rd, wr;
        rstn_a = 1'b0;
        rstn_b = 1'b0;
        drive(0, 1'b0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 1'b0, 0, 0, 0);
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        @(negedge clk);
        @(negedge clk);
        expect_outputs(0, "reset_a", 1'b0, 1'b0, 1'b0, 8'h00);
        expect_outputs(1, "reset_b", 1'b0, 1'b0, 1'b0, 8'h00);
        rstn_a = 1'b1;
        rstn_b = 1'b1;
        @(negedge clk);

        // Fill both arrays so every in-range word has a known value.
        for (int a = 0; a < A_DEPTH; a++)
            run_req(0, "fill_a", 1'b0, 1'b1, 0, a, int'($urandom_range(0, 255)), 1'b0);
        for (int a = 0; a < B_DEPTH; a++)
            run_req(1, "fill_b", 1'b0, 1'b1, 0, a, int'($urandom_range(0, 255)), 1'b0);

        // Write then read back at latency 1.
        run_req(0, "t1_wr", 1'b0, 1'b1, 0, 'h10, 'h5A, 1'b0);
        run_req(0, "t1_rd", 1'b1, 1'b0, 'h10, 0, 0, 1'b0);

        // Same-edge read and write to one address: old data first, new data after.
        run_req(0, "t2_pre", 1'b0, 1'b1, 0, 'h20, 'h11, 1'b0);
        run_req(0, "t2_rdwr", 1'b1, 1'b1, 'h20, 'h20, 'h22, 1'b0);
        run_req(0, "t2_rd", 1'b1, 1'b0, 'h20, 0, 0, 1'b0);

        // Read latency 3 with a stray write presented while busy; it must be dropped.
        run_req(1, "t3_rd", 1'b1, 1'b0, 'h05, 0, 0, 1'b1);
        run_req(1, "t3_reread", 1'b1, 1'b0, 'h05, 0, 0, 1'b0);

        // Out-of-range write and read on the 128-word array; word 0 must not alias.
        run_req(1, "t4_wr", 1'b0, 1'b1, 0, 'h80, 'hFF, 1'b0);
        run_req(1, "t4_rd", 1'b1, 1'b0, 'h80, 0, 0, 1'b0);
        run_req(1, "t4_rd0", 1'b1, 1'b0, 'h00, 0, 0, 1'b0);
        run_req(1, "t4_rd7f", 1'b1, 1'b0, 'h7F, 0, 0, 1'b0);

        // Reset two edges into a latency-4 write: write discarded, outputs cleared.
        drive(1, 1'b0, 1'b1, 0, 'h30, 'h77);
        @(negedge clk);
        expect_outputs(1, "t5@acc", 1'b1, 1'b0, 1'b0, last_rd[1]);
        drive(1, 1'b0, 1'b0, 0, 0, 0);
        @(negedge clk);
        expect_outputs(1, "t5@1", 1'b1, 1'b0, 1'b0, last_rd[1]);
        rstn_b = 1'b0;
        #1;
        expect_outputs(1, "t5_rst", 1'b0, 1'b0, 1'b0, 8'h00);
        last_rd[1] = 8'h00;
        @(negedge clk);
        rstn_b = 1'b1;
        @(negedge clk);
        @(negedge clk);
        expect_outputs(1, "t5_idle", 1'b0, 1'b0, 1'b0, 8'h00);
        run_req(1, "t5_rd", 1'b1, 1'b0, 'h30, 0, 0, 1'b0);

        // Back-to-back reads with the request held continuously.
        drive(0, 1'b1, 1'b0, 'h01, 0, 0);
        @(negedge clk);
        expect_outputs(0, "t6_a0", 1'b1, 1'b0, 1'b0, last_rd[0]);
        drive(0, 1'b1, 1'b0, 'h02, 0, 0);
        @(negedge clk);
        expect_outputs(0, "t6_a1", 1'b0, 1'b1, 1'b0, model[0][1]);
        @(negedge clk);
        expect_outputs(0, "t6_b0", 1'b1, 1'b0, 1'b0, model[0][1]);
        drive(0, 1'b0, 1'b0, 0, 0, 0);
        @(negedge clk);
        expect_outputs(0, "t6_b1", 1'b0, 1'b1, 1'b0, model[0][2]);
        last_rd[0] = model[0][2];

        // Randomized mixes of read, write and read+write on both instances.
        for (int inst = 0; inst < 2; inst++) begin
            for (int n = 0; n < 150; n++) begin
                rd = 1'($urandom_range(0, 1));
                wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
                ar = int'($urandom_range(0, 255));
                aw = ($urandom_range(0, 3) == 0) ? ar : int'($urandom_range(0, 255));
                if (inst == 1 && $urandom_range(0, 1) == 0) begin
                    ar = ar % B_DEPTH;
                    aw = aw % B_DEPTH;
                end
                dw = int'($urandom_range(0, 255));
                run_req(inst, $sformatf("rnd%0d_%0d", inst, n), rd, wr, ar, aw, dw, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
